program_loader: RTL and testbench

Host-side initiator for the CPU's programming handshake. It accepts a program image byte-by-byte from the external input pins and buffers it. It then drives `programming` and places one byte on the bus each time the control sequencer requests it, until the whole image is written to RAM. It sits between the `ui_in` pins and the shared bus/control block, and it is the only source of `programming`.

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_loader_fifo.sv | 57 +++++
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader and the control block:
//   - loader FSM state encodings (LD_IDLE .. LD_DONE)
//   - default image geometry (RAM depth, byte width)
//   - control-stage numbering T0..T5 plus the hold stage
package program_loader_pkg;

   localparam int LD_MEM_DEPTH  = 16;
   localparam int LD_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      LD_IDLE    = 3'd0,
      LD_COLLECT = 3'd1,
      LD_SYNC    = 3'd2,
      LD_STREAM  = 3'd3,
      LD_DONE    = 3'd4
   } ld_state_t;

   // Control-block stage numbering; one instruction slot is T0..T5 + hold.
   localparam int T0         = 0;
   localparam int T1         = 1;
   localparam int T2         = 2;
   localparam int T3         = 3;
   localparam int T4         = 4;
   localparam int T5         = 5;
   localparam int T_HOLD     = 6;
   localparam int NUM_STAGES = 7;

endpackage

// File: rtl/program_loader_fifo.sv
// prog_fifo
// Synchronous FIFO buffering the program image between host collection and
// bus streaming.
// Ports:
//   clk, resetn          clock, async active-low reset
//   i_push, i_data       write strobe and byte (ignored when full)
//   i_pop                read strobe (ignored when empty)
//   o_head               oldest stored byte
//   o_full, o_empty      occupancy flags
module prog_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push, w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   // Storage needs no reset: occupancy is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Collects a program image from the host pins, then, once the control block
// is at T0, drives `programming` and serves one byte per instruction slot on
// the bus until every collected byte has been written to RAM.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   ext_data/ext_valid/ext_last     host byte stream; ext_ready accepts it
//   ready/read_ui_in/done_load      control-block strobes (T0 / T3 / T4)
//   programming                     load mode for the control block
//   bus_out, bus_en                 byte driven onto the shared bus
//   prog_done                       one-cycle pulse after the final write
//   byte_count                      bytes collected for this image
module program_loader
   import program_loader_pkg::*;
#(
   parameter int MEM_DEPTH  = LD_MEM_DEPTH,
   parameter int DATA_WIDTH = LD_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [DATA_WIDTH-1:0]        ext_data,
   input  logic                         ext_valid,
   input  logic                         ext_last,
   output logic                         ext_ready,
   input  logic                         ready,
   input  logic                         read_ui_in,
   input  logic                         done_load,
   output logic                         programming,
   output logic [DATA_WIDTH-1:0]        bus_out,
   output logic                         bus_en,
   output logic                         prog_done,
   output logic [$clog2(MEM_DEPTH):0]   byte_count
);
   localparam int CW = $clog2(MEM_DEPTH) + 1;

   ld_state_t             r_state;
   logic [CW-1:0]         r_byte_count, r_wr_count;
   logic                  r_programming, r_prog_done;
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  r_held;

   logic                  w_full, w_empty, w_xfer, w_pop, w_to_sync;
   logic [DATA_WIDTH-1:0] w_head;
   logic [CW-1:0]         w_cnt_nxt;

   // Gated with resetn so the pin reads 0 while reset is held, yet IDLE
   // accepts the very first byte without a wasted cycle.
   assign ext_ready = resetn & ((r_state == LD_IDLE) |
                                ((r_state == LD_COLLECT) & ~w_full));
   assign w_xfer    = ext_valid & ext_ready;
   assign w_cnt_nxt = r_byte_count + CW'(1);
   assign w_to_sync = ext_last | (w_cnt_nxt == CW'(MEM_DEPTH));
   assign w_pop     = (r_state == LD_STREAM) & read_ui_in & ~w_empty;

   prog_fifo #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_xfer),
      .i_data  (ext_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // The pop lands mid-way through the read_ui_in window; the popped byte
   // is held until read_ui_in is seen low so the bus stays stable for the
   // control block's whole T3 window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hold <= '0;
         r_held <= 1'b0;
      end else if (w_pop) begin
         r_hold <= w_head;
         r_held <= 1'b1;
      end else if (!read_ui_in) begin
         r_held <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= LD_IDLE;
         r_byte_count  <= '0;
         r_wr_count    <= '0;
         r_programming <= 1'b0;
         r_prog_done   <= 1'b0;
      end else begin
         r_prog_done <= 1'b0;
         case (r_state)
            LD_IDLE, LD_COLLECT: begin
               if (w_xfer) begin
                  r_byte_count <= w_cnt_nxt;
                  r_state      <= w_to_sync ? LD_SYNC : LD_COLLECT;
               end
            end
            // Enter load mode only from T0 so the first programming cycle
            // is T1 of a fresh instruction with the MAR holding the PC.
            LD_SYNC: begin
               if (ready) begin
                  r_programming <= 1'b1;
                  r_wr_count    <= '0;
                  r_state       <= LD_STREAM;
               end
            end
            LD_STREAM: begin
               if (done_load) begin
                  r_wr_count <= r_wr_count + CW'(1);
                  if (r_wr_count + CW'(1) == r_byte_count) begin
                     r_programming <= 1'b0;
                     r_prog_done   <= 1'b1;
                     r_state       <= LD_DONE;
                  end
               end
            end
            default: r_state <= LD_DONE;
         endcase
      end
   end

   assign programming = r_programming;
   assign prog_done   = r_prog_done;
   assign byte_count  = r_byte_count;
   assign bus_en      = r_programming & read_ui_in;
   assign bus_out     = r_held ? r_hold : (w_empty ? '0 : w_head);

   // The sequencer never asks for more bytes than were collected.
   a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
      !((r_state == LD_STREAM) && read_ui_in && w_empty));

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] ext_data;
   logic       ext_valid, ext_last, ext_ready;
   logic       ready, read_ui_in, done_load;
   logic       programming, bus_en, prog_done;
   logic [7:0] bus_out;
   logic [4:0] byte_count;

   program_loader dut (
      .clk(clk), .resetn(resetn), .ext_data(ext_data), .ext_valid(ext_valid),
      .ext_last(ext_last), .ext_ready(ext_ready), .ready(ready),
      .read_ui_in(read_ui_in), .done_load(done_load), .programming(programming),
      .bus_out(bus_out), .bus_en(bus_en), .prog_done(prog_done),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int stage, cyc = 0, last_acc_cyc = 0;
   int exp_cnt = 0, writes = 0, pulses = 0;
   logic [7:0] sb[$];
   logic [7:0] img[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Control-block model: one stage per falling edge, T0..T5 + hold.
   // Strobes run continuously, so they are stray whenever not streaming.
   initial begin
      ready = 0; read_ui_in = 0; done_load = 0; stage = 6;
      forever begin
         @(negedge clk);
         if (!resetn) stage = 0;
         else stage = (stage == 6) ? 0 : stage + 1;
         ready      = (stage == 0);
         read_ui_in = (stage == 3);
         done_load  = (stage == 4);
      end
   end

   // Monitor: samples mid-cycle, pops the scoreboard on every bus window.
   initial begin
      logic prev_prog, prev_done;
      logic [7:0] exp;
      prev_prog = 0; prev_done = 0;
      forever begin
         @(negedge clk); #2;
         if (!resetn) begin prev_prog = 0; prev_done = 0; continue; end
         if (programming && !prev_prog) begin
            chk("prog_phase_T1", stage, 1);
            chk("prog_latency_ok", ((cyc - last_acc_cyc) >= 1 && (cyc - last_acc_cyc) <= 8), 1);
         end
         if (prog_done) begin
            if (!prev_done) pulses++;
            chk("prog_done_width", prev_done, 0);
            chk("done_writes", writes, exp_cnt);
            chk("done_sb_empty", sb.size(), 0);
            chk("done_byte_count", byte_count, exp_cnt);
            chk("done_prog_low", programming, 0);
         end
         if (done_load && programming) writes++;
         prev_prog = programming;
         prev_done = prog_done;
         if (bus_en) begin
            if (sb.size() == 0) begin
               chk("bus_unexpected", bus_out, 8'hxx);
            end else begin
               exp = sb.pop_front();
               chk("bus_byte", bus_out, exp);
               #6;
               if (resetn && read_ui_in) chk("bus_stable", bus_out, exp);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit last);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      ext_data = d; ext_valid = 1; ext_last = last;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ext_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      ext_valid = 0; ext_last = 0;
      chk("accept_timeout", ok, 1);
      if (ok) begin
         sb.push_back(d);
         exp_cnt++;
         last_acc_cyc = cyc - 0;
         chk("byte_count_inc", byte_count, exp_cnt);
      end
   endtask

   task automatic wait_stage(input int s);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk); #1;
         if (stage == s) break;
      end
   endtask

   task automatic run_load(input int gap, input bit use_last, input bit phase);
      for (int i = 0; i < img.size(); i++) begin
         if (phase && i == img.size() - 1) wait_stage(1);
         send_byte(img[i], use_last && (i == img.size() - 1));
         repeat (gap) @(posedge clk);
      end
   endtask

   task automatic wait_done();
      int base;
      bit ok;
      base = pulses; ok = 0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk);
         if (pulses > base) begin ok = 1; break; end
      end
      chk("done_timeout", ok, 1);
      repeat (3) @(posedge clk);
      #1 chk("single_pulse", pulses, base + 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      resetn = 0;
      #1;
      chk("rst_programming", programming, 0);
      chk("rst_bus_en", bus_en, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_ext_ready", ext_ready, 0);
      chk("rst_prog_done", prog_done, 0);
      chk("rst_bus_out", bus_out, 0);
      sb.delete(); exp_cnt = 0; writes = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      resetn = 1;
   endtask

   task automatic rand_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
   endtask

   initial begin
      int n;
      resetn = 1; ext_data = 0; ext_valid = 0; ext_last = 0;
      #2 resetn = 0;
      #1;
      chk("rst_programming", programming, 0);
      chk("rst_ext_ready", ext_ready, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_bus_out", bus_out, 0);
      repeat (3) @(posedge clk);
      #1 resetn = 1;

      // Stray strobes while IDLE.
      repeat (15) @(posedge clk);
      #1;
      chk("idle_byte_count", byte_count, 0);
      chk("idle_ext_ready", ext_ready, 1);

      // Four-byte reference image.
      img = '{8'h41, 8'h25, 8'h50, 8'h00};
      run_load(0, 1, 0);
      wait_done();
      chk("img4_byte_count", byte_count, 4);

      // Stray strobes and host offers while DONE.
      repeat (20) @(posedge clk);
      #1 ext_valid = 1; ext_data = 8'h77; ext_last = 1;
      @(negedge clk);
      chk("done_ext_ready", ext_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_hold_count", byte_count, 4);
      chk("done_hold_prog", programming, 0);
      ext_valid = 0; ext_last = 0;

      // Full image, no ext_last, 17th byte refused.
      do_reset();
      rand_img(16);
      run_load(0, 0, 0);
      @(posedge clk); #1 ext_valid = 1; ext_data = 8'hEE;
      @(negedge clk);
      chk("full_ext_ready", ext_ready, 0);
      repeat (3) @(posedge clk);
      #1 chk("full_byte_count", byte_count, 16);
      ext_valid = 0;
      wait_done();

      // Phase alignment: last byte lands so SYNC starts with T3 next.
      do_reset();
      rand_img(3);
      run_load(0, 1, 1);
      wait_done();

      // Host back-pressure.
      do_reset();
      rand_img(7);
      run_load(3, 1, 0);
      wait_done();

      // Mid-stream reset after the 2nd write, then a clean reload.
      do_reset();
      rand_img(5);
      run_load(0, 1, 0);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk); #3;
         if (writes >= 2) break;
      end
      chk("mid_writes_reached", writes, 2);
      chk("mid_prog_before", programming, 1);
      do_reset();
      rand_img(6);
      run_load(1, 1, 0);
      wait_done();

      // Random images.
      for (int k = 0; k < 4; k++) begin
         do_reset();
         n = $urandom_range(1, 16);
         rand_img(n);
         run_load($urandom_range(0, 3), (n < 16) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
         wait_done();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=%0d required=%0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
